// File: rtl/adder_pipelined.sv
// Pipelined WIDTH-bit adder/subtractor. The carry chain is cut into STAGES slices of
// CHUNK bits; each stage adds its slice and forwards the rest of the beat downstream.
// Flow control is a per-stage valid bit with a combinational ready chain.
module adder_pipelined #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = int'((WIDTH + STAGES - 1) / STAGES);
  localparam int LAST  = int'(STAGES) - 1;

  // Per-stage beat state: raw operands, partially completed sum, slice carry, op select
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] sub_q;

  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] valid_in;
  logic [STAGES-1:0] sub_in;
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  a_in  [STAGES];
  logic [WIDTH-1:0]  b_in  [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  // Ready chain: a stage can take a beat if it is empty or the stage after it moves
  always_comb begin
    logic r;
    ready = '0;
    r     = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      r        = ~valid_q[k] | r;
      ready[k] = r;
    end
  end

  assign in_ready = ready[0];

  // Stage inputs and slice arithmetic; bits outside a stage's slice pass through
  always_comb begin
    logic             c;
    logic [WIDTH-1:0] bx;
    int               p;
    valid_in = '0;
    sub_in   = '0;
    carry_d  = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      p = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        valid_in[k] = in_valid;
        a_in[k]     = a;
        b_in[k]     = b;
        sub_in[k]   = sub;
        sum_d[k]    = '0;
        c           = sub | cin;
      end else begin
        valid_in[k] = valid_q[p];
        a_in[k]     = a_q[p];
        b_in[k]     = b_q[p];
        sub_in[k]   = sub_q[p];
        sum_d[k]    = sum_q[p];
        c           = carry_q[p];
      end
      bx = b_in[k] ^ {WIDTH{sub_in[k]}};
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (i >= k * CHUNK && i < (k + 1) * CHUNK) begin
          sum_d[k][i] = a_in[k][i] ^ bx[i] ^ c;
          c           = (a_in[k][i] & bx[i]) | (c & (a_in[k][i] ^ bx[i]));
        end
      end
      carry_d[k] = c;
    end
  end

  // Stage registers: a stage holds while its downstream neighbour is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      sub_q   <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (ready[k]) begin
          valid_q[k] <= valid_in[k];
          a_q[k]     <= a_in[k];
          b_q[k]     <= b_in[k];
          sum_q[k]   <= sum_d[k];
          carry_q[k] <= carry_d[k];
          sub_q[k]   <= sub_in[k];
        end
      end
    end
  end

  // Outputs from the final stage; overflow uses the effective (possibly inverted) B sign
  always_comb begin
    logic b_msb;
    b_msb     = b_q[LAST][WIDTH-1] ^ sub_q[LAST];
    out_valid = valid_q[LAST];
    sum       = sum_q[LAST];
    cout      = carry_q[LAST];
    ovf       = (a_q[LAST][WIDTH-1] == b_msb) & (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
  end

endmodule

// File: tb/tb_adder_pipelined.sv
// Scoreboard bench: a W=8/S=2 instance runs directed, backpressure and reset tests,
// and a set of extra instances sweeps WIDTH/STAGES with random full-rate traffic.
module tb_adder_pipelined;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int N_SW = 7;
  localparam int SW_W [N_SW] = '{1, 8, 8, 8, 13, 13, 13};
  localparam int SW_S [N_SW] = '{1, 1, 3, 8, 1, 3, 13};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sw_finished = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Main instance
  logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  adder_pipelined #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  function automatic res_t model(input logic [W-1:0] x, y, input logic c, s);
    logic [W-1:0] yx;
    logic [W:0]   t;
    res_t         r;
    yx  = s ? ~y : y;
    t   = {1'b0, x} + {1'b0, yx} + {{W{1'b0}}, (s | c)};
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = (x[W-1] == yx[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  res_t         exp_q[$];
  logic [W-1:0] rx_q[$];
  logic         in_fire, out_fire, stalled, saw_full;
  logic [10:0]  held;
  logic [W-1:0] last_sum;
  logic         last_cout, last_ovf;

  // One cycle: sample #1 after the falling edge, score transfers, advance to next falling edge
  task automatic step();
    res_t e;
    #1;
    in_fire  = 1'b0;
    out_fire = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      chk("in_ready", in_ready, (exp_q.size() < S) || out_ready);
      if (!in_ready) saw_full = 1'b1;
      if (exp_q.size() == 0) chk("idle_out_valid", out_valid, 0);
      if (stalled) chk("stall_hold", {out_valid, sum, cout, ovf}, held);
      stalled = out_valid && !out_ready;
      held    = {out_valid, sum, cout, ovf};
      if (out_valid && out_ready) begin
        out_fire = 1'b1;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", sum, e.s);
          chk("cout", cout, e.c);
          chk("ovf", ovf, e.o);
        end
        last_sum  = sum;
        last_cout = cout;
        last_ovf  = ovf;
        rx_q.push_back(sum);
      end
      if (in_valid && in_ready) begin
        in_fire = 1'b1;
        exp_q.push_back(model(a, b, cin, sub));
      end
    end
    @(negedge clk);
  endtask

  task automatic send_one(input string tag, input logic [W-1:0] x, y, input logic c, s,
                          input logic [W-1:0] es, input logic ec, eo);
    int lat;
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk({tag, "_accept"}, in_fire, 1);
    in_valid = 1'b0;
    lat      = 0;
    out_fire = 1'b0;
    while (!out_fire && lat < 10) begin
      lat++;
      step();
    end
    chk({tag, "_latency"}, lat, S);
    chk({tag, "_sum"}, last_sum, es);
    chk({tag, "_cout"}, last_cout, ec);
    chk({tag, "_ovf"}, last_ovf, eo);
  endtask

  initial begin
    int i, cyc, sent;
    stalled = 1'b0; saw_full = 1'b0;
    rst_n = 1'b0; in_valid = 1'b1; a = 8'h55; b = 8'h0f; cin = 1'b1; sub = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_in_ready", in_ready, 1);
      if (k == 1) begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
      end
      @(negedge clk);
    end

    send_one("add_wrap", 8'hff, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    send_one("add_ovf", 8'h7f, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    send_one("sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7f, 1'b1, 1'b1);
    send_one("sub_cin_ign", 8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

    // Backpressure: stream 0..9 + 1 with out_ready toggling
    rx_q.delete();
    saw_full = 1'b0;
    i = 0; cyc = 0;
    while ((i < 10 || exp_q.size() > 0) && cyc < 200) begin
      in_valid = (i < 10); a = i[W-1:0]; b = 8'h01; cin = 1'b0; sub = 1'b0;
      out_ready = (cyc % 2 == 0);
      step();
      if (in_fire) i++;
      cyc++;
    end
    chk("bp_in_time", cyc < 200, 1);
    chk("bp_count", rx_q.size(), 10);
    chk("bp_saw_full", saw_full, 1);
    for (int k = 0; k < 10; k++)
      if (k < rx_q.size()) chk("bp_order", rx_q[k], k + 1);

    // Reset with two beats in flight
    in_valid = 1'b1; out_ready = 1'b0; a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
    step();
    chk("mid_accept0", in_fire, 1);
    a = 8'h33;
    step();
    chk("mid_accept1", in_fire, 1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("mid_flush_out_valid", out_valid, 0);
    end

    // Random traffic with random backpressure
    sent = 0; cyc = 0;
    while ((sent < 30 || exp_q.size() > 0) && cyc < 600) begin
      in_valid  = (sent < 30) && ($urandom_range(0, 3) != 0);
      a         = 8'($urandom());
      b         = 8'($urandom());
      cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (in_fire) sent++;
      cyc++;
    end
    chk("rand_in_time", cyc < 600, 1);
    in_valid = 1'b0;

    cyc = 0;
    while (sw_finished < N_SW && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("sweep_done", sw_finished, N_SW);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Parameter sweep: full-rate random traffic, exact beat count within N + STAGES cycles
  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    localparam int SWW = SW_W[g];
    localparam int SWS = SW_S[g];
    localparam int NB  = 40;

    logic           rn, iv, ir, ci, sb, ov, orr, co, of;
    logic [SWW-1:0] aa, bb, sm;
    logic [SWW+1:0] sq[$];

    adder_pipelined #(.WIDTH(SWW), .STAGES(SWS)) u_sw (
      .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir), .a(aa), .b(bb), .cin(ci),
      .sub(sb), .out_valid(ov), .out_ready(orr), .sum(sm), .cout(co), .ovf(of)
    );

    function automatic logic [SWW+1:0] ref_fn(input logic [SWW-1:0] x, y, input logic c, s);
      logic [SWW-1:0] yx;
      logic [SWW:0]   t;
      yx = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, yx} + {{SWW{1'b0}}, (s | c)};
      return {(x[SWW-1] == yx[SWW-1]) && (t[SWW-1] != x[SWW-1]), t[SWW], t[SWW-1:0]};
    endfunction

    initial begin
      int             sent, rcvd, r;
      logic [SWW+1:0] e;
      rn = 1'b0; iv = 1'b0; orr = 1'b1; aa = '0; bb = '0; ci = 1'b0; sb = 1'b0;
      repeat (2) @(negedge clk);
      rn = 1'b1;
      sent = 0; rcvd = 0;
      for (int cyc = 0; cyc < NB + SWS; cyc++) begin
        iv = (sent < NB);
        r  = int'($urandom()); aa = r[SWW-1:0];
        r  = int'($urandom()); bb = r[SWW-1:0];
        ci = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        #1;
        if (iv) chk($sformatf("sw%0d_in_ready", g), ir, 1);
        if (ov) begin
          if (sq.size() == 0) begin
            chk($sformatf("sw%0d_spurious", g), 1, 0);
          end else begin
            e = sq.pop_front();
            chk($sformatf("sw%0d_result", g), {of, co, sm}, e);
          end
          rcvd++;
        end
        if (iv && ir) begin
          sq.push_back(ref_fn(aa, bb, ci, sb));
          sent++;
        end
        @(negedge clk);
      end
      chk($sformatf("sw%0d_count", g), rcvd, NB);
      sw_finished++;
    end
  end

endmodule
